// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: immediate selector, instruction field positions, zero register.
package id_pkg;

    typedef enum logic [1:0] {
        IMM_ALU12  = 2'd0,
        IMM_DT9    = 2'd1,
        IMM_COND19 = 2'd2,
        IMM_BR26   = 2'd3
    } imm_sel_e;

    localparam int REG_IDX_W  = 5;
    localparam int RD_LSB     = 0;
    localparam int RN_LSB     = 5;
    localparam int RM_LSB     = 16;

    localparam int IMM12_LSB  = 10;
    localparam int IMM12_W    = 12;
    localparam int DT9_LSB    = 12;
    localparam int DT9_W      = 9;
    localparam int COND19_LSB = 5;
    localparam int COND19_W   = 19;
    localparam int BR26_LSB   = 0;
    localparam int BR26_W     = 26;

    function automatic logic [REG_IDX_W-1:0] xzr_of(input int num_regs);
        return REG_IDX_W'(num_regs - 1);
    endfunction

    localparam logic [REG_IDX_W-1:0] XZR_IDX = xzr_of(32);

endpackage

// File: rtl/regfile_wf.sv
// Two-read / one-write register file with write-first bypass; the top index (XZR) and above read as 0.
module regfile_wf
    import id_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [DATA_W-1:0]    wd,
    input  logic [REG_IDX_W-1:0] ra_a,
    input  logic [REG_IDX_W-1:0] ra_b,
    output logic [DATA_W-1:0]    rd_a,
    output logic [DATA_W-1:0]    rd_b
);

    // XZR has no storage; only indices below it are backed by flops
    localparam int NSTORE = NUM_REGS - 1;

    logic [DATA_W-1:0]    mem  [NSTORE];
    logic [REG_IDX_W-1:0] ra   [2];
    logic [DATA_W-1:0]    rdat [2];

    assign ra[0] = ra_a;
    assign ra[1] = ra_b;
    assign rd_a  = rdat[0];
    assign rd_b  = rdat[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NSTORE; i++) mem[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < NSTORE; i++)
                if (wa == REG_IDX_W'(i)) mem[i] <= wd;
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdat[p] = '0;
            for (int i = 0; i < NSTORE; i++)
                if (ra[p] == REG_IDX_W'(i))
                    rdat[p] = (we && wa == ra[p]) ? wd : mem[i];
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined LEGv8 decode stage: regfile read, immediate extend, forwarding, hazard stall and the ID/EX register.
// Define ID_FWD_EN for EX/MEM operand forwarding; otherwise any RAW on EX/MEM stalls.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int CTRL_W   = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 if_valid,
    input  logic [31:0]          instr,
    input  logic [DATA_W-1:0]    pc_if,
    input  logic [CTRL_W-1:0]    ctrl_in,
    input  logic                 Reg2Loc,
    input  logic                 use_ra,
    input  logic                 use_rb,
    input  logic [1:0]           imm_sel,
    input  logic                 flush,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 ex_reg_write,
    input  logic                 mem_reg_write,
    input  logic                 wb_reg_write,
    input  logic                 ex_mem_read,
    input  logic [DATA_W-1:0]    ex_result,
    input  logic [DATA_W-1:0]    mem_result,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 id_valid,
    output logic [DATA_W-1:0]    pc_id,
    output logic [DATA_W-1:0]    Da,
    output logic [DATA_W-1:0]    Db,
    output logic [DATA_W-1:0]    imm_ext,
    output logic [REG_IDX_W-1:0] rd_id,
    output logic [CTRL_W-1:0]    ctrl_id,
    output logic                 stall_if
);

    localparam logic [REG_IDX_W-1:0] XZR = xzr_of(NUM_REGS);

    logic [REG_IDX_W-1:0] rn, rb_src, rd;
    logic [DATA_W-1:0]    rf_a, rf_b, opa, opb, imm_c;
    logic                 rn_live, rb_live;
    logic                 ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic                 hazard;

    assign rn      = instr[RN_LSB +: REG_IDX_W];
    assign rd      = instr[RD_LSB +: REG_IDX_W];
    assign rb_src  = Reg2Loc ? instr[RM_LSB +: REG_IDX_W] : rd;
    // XZR and any out-of-range index are constant zero and never match a producer
    assign rn_live = rn < XZR;
    assign rb_live = rb_src < XZR;

    assign ex_hit_a  = ex_reg_write  && ex_rd  == rn     && rn_live;
    assign ex_hit_b  = ex_reg_write  && ex_rd  == rb_src && rb_live;
    assign mem_hit_a = mem_reg_write && mem_rd == rn     && rn_live;
    assign mem_hit_b = mem_reg_write && mem_rd == rb_src && rb_live;

    regfile_wf #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wb_reg_write),
        .wa      (wb_rd),
        .wd      (wb_data),
        .ra_a    (rn),
        .ra_b    (rb_src),
        .rd_a    (rf_a),
        .rd_b    (rf_b)
    );

`ifdef ID_FWD_EN
    // EX is younger than MEM, so it takes priority; both beat the WB bypass inside the regfile
    assign opa    = !rn_live ? '0 : ex_hit_a ? ex_result : mem_hit_a ? mem_result : rf_a;
    assign opb    = !rb_live ? '0 : ex_hit_b ? ex_result : mem_hit_b ? mem_result : rf_b;
    assign hazard = if_valid && ex_mem_read &&
                    ((use_ra && ex_hit_a) || (use_rb && ex_hit_b));
`else
    assign opa    = rf_a;
    assign opb    = rf_b;
    assign hazard = if_valid &&
                    ((use_ra && (ex_hit_a || mem_hit_a)) || (use_rb && (ex_hit_b || mem_hit_b)));
`endif

    assign stall_if = reset_n && hazard && !flush;

    always_comb begin
        imm_c = '0;
        case (imm_sel_e'(imm_sel))
            IMM_ALU12:  imm_c = DATA_W'(instr[IMM12_LSB +: IMM12_W]);
            IMM_DT9:    imm_c = DATA_W'($signed(instr[DT9_LSB +: DT9_W]));
            IMM_COND19: imm_c = DATA_W'($signed(instr[COND19_LSB +: COND19_W]));
            IMM_BR26:   imm_c = DATA_W'($signed(instr[BR26_LSB +: BR26_W]));
            default:    imm_c = '0;
        endcase
    end

    // Stall and flush both insert a bubble; payload is held since it is don't-care
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid <= 1'b0;
            pc_id    <= '0;
            Da       <= '0;
            Db       <= '0;
            imm_ext  <= '0;
            rd_id    <= '0;
            ctrl_id  <= '0;
        end else if (flush || hazard) begin
            id_valid <= 1'b0;
        end else begin
            id_valid <= if_valid;
            pc_id    <= pc_if;
            Da       <= opa;
            Db       <= opb;
            imm_ext  <= imm_c;
            rd_id    <= rd;
            ctrl_id  <= ctrl_in;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe; expectations follow ID_FWD_EN when the build defines it.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_valid;
    logic [31:0] instr;
    logic [63:0] pc_if;
    logic [11:0] ctrl_in;
    logic        Reg2Loc, use_ra, use_rb, flush;
    logic [1:0]  imm_sel;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_read;
    logic [63:0] ex_result, mem_result, wb_data;
    logic        id_valid, stall_if;
    logic [63:0] pc_id, Da, Db, imm_ext;
    logic [4:0]  rd_id;
    logic [11:0] ctrl_id;

    int n_chk = 0;
    int n_err = 0;

    id_stage_pipe #(.DATA_W(64), .NUM_REGS(32), .CTRL_W(12)) dut (
        .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .instr(instr), .pc_if(pc_if),
        .ctrl_in(ctrl_in), .Reg2Loc(Reg2Loc), .use_ra(use_ra), .use_rb(use_rb),
        .imm_sel(imm_sel), .flush(flush), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .ex_mem_read(ex_mem_read), .ex_result(ex_result), .mem_result(mem_result),
        .wb_data(wb_data), .id_valid(id_valid), .pc_id(pc_id), .Da(Da), .Db(Db),
        .imm_ext(imm_ext), .rd_id(rd_id), .ctrl_id(ctrl_id), .stall_if(stall_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [4:0] rn, input logic [4:0] rm,
                                        input logic [4:0] rd);
        return {11'd0, rm, 6'd0, rn, rd};
    endfunction

    task automatic clr();
        if_valid = 0; instr = '0; pc_if = '0; ctrl_in = '0;
        Reg2Loc = 0; use_ra = 0; use_rb = 0; imm_sel = 2'd0; flush = 0;
        ex_rd = 5'd31; mem_rd = 5'd31; wb_rd = 5'd31;
        ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0; ex_mem_read = 0;
        ex_result = '0; mem_result = '0; wb_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_hazard_on_rm9();
        if_valid = 1; instr = ins(5'd0, 5'd9, 5'd1); Reg2Loc = 1; use_rb = 1;
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd9; ex_result = 64'hBAD;
    endtask

    initial begin
        clr();
        reset_n = 0;
        load_hazard_on_rm9();
        #3;
        chk("rst_stall", stall_if, 0);
        chk("rst_valid", id_valid, 0);
        chk("rst_da", Da, 0);
        chk("rst_db", Db, 0);
        step();
        reset_n = 1;
        clr();

        // preload X3, X9; write to XZR must be dropped
        wb_reg_write = 1; wb_rd = 5'd3;  wb_data = 64'd7;    step();
        wb_rd = 5'd9;  wb_data = 64'h99;   step();
        wb_rd = 5'd31; wb_data = 64'hDEAD; step();
        clr();

        // WB write-first bypass
        if_valid = 1; instr = ins(5'd5, 5'd0, 5'd12); use_ra = 1;
        pc_if = 64'h1000; ctrl_in = 12'hABC;
        wb_reg_write = 1; wb_rd = 5'd5; wb_data = 64'h45;
        step();
        chk("wb_byp_valid", id_valid, 1);
        chk("wb_byp_da", Da, 64'h45);
        chk("wb_byp_pc", pc_id, 64'h1000);
        chk("wb_byp_rd", rd_id, 5'd12);
        chk("wb_byp_ctrl", ctrl_id, 12'hABC);
        clr();

        // XZR reads zero even with EX writing X31
        if_valid = 1; instr = ins(5'd31, 5'd31, 5'd0); Reg2Loc = 1; use_ra = 1; use_rb = 1;
        ex_reg_write = 1; ex_rd = 5'd31; ex_result = 64'hBAD;
        #1 chk("xzr_stall", stall_if, 0);
        step();
        chk("xzr_da", Da, 0);
        chk("xzr_db", Db, 0);
        clr();

        // plain regfile read, port B from Rd
        if_valid = 1; instr = ins(5'd9, 5'd0, 5'd3); use_ra = 1; use_rb = 1;
        step();
        chk("rf_da", Da, 64'h99);
        chk("rf_db", Db, 64'd7);
        chk("rf_rd", rd_id, 5'd3);
        clr();

        // EX match on Rn
        if_valid = 1; instr = ins(5'd3, 5'd0, 5'd1); use_ra = 1;
        ex_reg_write = 1; ex_rd = 5'd3; ex_result = 64'h1234;
`ifdef ID_FWD_EN
        #1 chk("exf_stall", stall_if, 0);
        step();
        chk("exf_valid", id_valid, 1);
        chk("exf_da", Da, 64'h1234);
`else
        #1 chk("exf_stall", stall_if, 1);
        step();
        chk("exf_bubble", id_valid, 0);
`endif
        clr();

        // MEM match on Rm
        if_valid = 1; instr = ins(5'd0, 5'd9, 5'd1); Reg2Loc = 1; use_rb = 1;
        mem_reg_write = 1; mem_rd = 5'd9; mem_result = 64'h5555;
`ifdef ID_FWD_EN
        #1 chk("memf_stall", stall_if, 0);
        step();
        chk("memf_db", Db, 64'h5555);
`else
        #1 chk("memf_stall", stall_if, 1);
        step();
        chk("memf_bubble", id_valid, 0);
`endif
        clr();

        // load-use on Rm, then producer walks to MEM and WB
        load_hazard_on_rm9();
        #1 chk("lu_stall", stall_if, 1);
        step();
        chk("lu_bubble", id_valid, 0);
        ex_mem_read = 0; ex_reg_write = 0; ex_rd = 5'd31;
        mem_reg_write = 1; mem_rd = 5'd9; mem_result = 64'h777;
`ifdef ID_FWD_EN
        #1 chk("lu_mem_stall", stall_if, 0);
        step();
        chk("lu_mem_valid", id_valid, 1);
        chk("lu_mem_db", Db, 64'h777);
`else
        #1 chk("lu_mem_stall", stall_if, 1);
        step();
        chk("lu_mem_bubble", id_valid, 0);
`endif
        mem_reg_write = 0; mem_rd = 5'd31;
        wb_reg_write = 1; wb_rd = 5'd9; wb_data = 64'h888;
        #1 chk("lu_wb_stall", stall_if, 0);
        step();
        chk("lu_wb_valid", id_valid, 1);
        chk("lu_wb_db", Db, 64'h888);
        clr();

        // hazard gated by use_rb and by if_valid
        load_hazard_on_rm9(); use_rb = 0;
        #1 chk("nouse_stall", stall_if, 0);
        use_rb = 1; if_valid = 0;
        #1 chk("noval_stall", stall_if, 0);
        step();
        chk("noval_valid", id_valid, 0);
        clr();

        // flush overrides stall
        load_hazard_on_rm9(); flush = 1;
        #1 chk("flush_stall", stall_if, 0);
        step();
        chk("flush_valid", id_valid, 0);
        clr();

        // immediates
        if_valid = 1;
        imm_sel = 2'd3; instr = 32'h03FF_FFFF; step();
        chk("imm_br26", imm_ext, 64'hFFFF_FFFF_FFFF_FFFF);
        imm_sel = 2'd0; instr = 32'h003F_FC00; step();
        chk("imm_alu12", imm_ext, 64'h0000_0000_0000_0FFF);
        imm_sel = 2'd1; instr = 32'h0010_0000; step();
        chk("imm_dt9", imm_ext, 64'hFFFF_FFFF_FFFF_FF00);
        imm_sel = 2'd2; instr = 32'h007F_FFE0; step();
        chk("imm_cond19", imm_ext, 64'h0000_0000_0003_FFFF);
        clr();

        // asynchronous reset mid-operation
        if_valid = 1; instr = ins(5'd3, 5'd9, 5'd2); Reg2Loc = 1; use_ra = 1; use_rb = 1;
        step();
        chk("pre_rst_valid", id_valid, 1);
        chk("pre_rst_da", Da, 64'd7);
        #2 reset_n = 0;
        #1;
        chk("arst_valid", id_valid, 0);
        chk("arst_da", Da, 0);
        chk("arst_db", Db, 0);
        step();
        reset_n = 1;
        step();
        chk("rf_cleared", Da, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
